// File: rtl/data_array_pkg.sv
// Shared defaults and FSM state type for the single-port SRAM line-array controller.
package data_array_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned DEF_DATA_WIDTH = 256;
    localparam int unsigned DEF_NUM_WMASKS = DEF_DATA_WIDTH / 8;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer favours the requester not granted last.
module rr_arb2
    import data_array_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;

    // ptr_q=1 means b wins the next contested cycle
    always_comb begin
        gnt_o = req_i;
        ptr_d = ptr_q;
        if (req_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end
        if (|gnt_o) begin
            ptr_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/data_array_ctrl.sv
// Two-requester front end for a single-port line SRAM with optional zero-fill sweep.
module data_array_ctrl
    import data_array_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned NUM_WMASKS = DEF_NUM_WMASKS,
    parameter bit          INIT_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [NUM_WMASKS-1:0] a_wmask,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    input  logic                  a_rready,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [NUM_WMASKS-1:0] b_wmask,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    input  logic                  b_rready,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic                  init_done
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rvalid_q, rvalid_d;
    logic                  owner_q, owner_d;
    logic [1:0]            arb_req, arb_gnt;
    logic                  run, hold, issue, sel_b, sel_we, issue_rd;

    // An unconsumed response blocks every access: any SRAM cycle would overwrite dout0
    assign run      = (state_q == RUN) && !rst;
    assign hold     = rvalid_q && !(owner_q ? b_rready : a_rready);
    assign arb_req  = (run && !hold) ? {b_req, a_req} : 2'b00;
    assign issue    = |arb_gnt;
    assign sel_b    = arb_gnt[1];
    assign sel_we   = sel_b ? b_we : a_we;
    assign issue_rd = issue && !sel_we;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (arb_req),
        .gnt_o (arb_gnt)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rvalid_d = rvalid_q;
        owner_d  = owner_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == '1) begin
                state_d = RUN;
            end
        end
        if (issue_rd) begin
            rvalid_d = 1'b1;
            owner_d  = sel_b;
        end else if (rvalid_q && !hold) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= INIT_EN ? INIT : RUN;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            owner_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            owner_q  <= owner_d;
        end
    end

    // SRAM port: sweep write, granted access, or idle with quiet zeros
    always_comb begin
        csb0   = 1'b1;
        web0   = 1'b1;
        addr0  = '0;
        wmask0 = '0;
        din0   = '0;
        if (!rst && state_q == INIT) begin
            csb0   = 1'b0;
            web0   = 1'b0;
            addr0  = cnt_q;
            wmask0 = '1;
        end else if (issue) begin
            csb0   = 1'b0;
            web0   = !sel_we;
            addr0  = sel_b ? b_addr  : a_addr;
            wmask0 = sel_b ? b_wmask : a_wmask;
            din0   = sel_b ? b_wdata : a_wdata;
        end
    end

    assign a_gnt     = arb_gnt[0];
    assign b_gnt     = arb_gnt[1];
    assign a_rvalid  = rvalid_q && !owner_q && !rst;
    assign b_rvalid  = rvalid_q && owner_q && !rst;
    assign a_rdata   = dout0;
    assign b_rdata   = dout0;
    assign init_done = run;

endmodule

// File: tb/tb_data_array_ctrl.sv
// Bench for data_array_ctrl: behavioural SRAM, reference memory, read-response scoreboard.
module tb_data_array_ctrl;
    import data_array_pkg::*;

    localparam int unsigned AW = DEF_ADDR_WIDTH;
    localparam int unsigned DW = DEF_DATA_WIDTH;
    localparam int unsigned MW = DEF_NUM_WMASKS;
    localparam int unsigned NL = 2 ** AW;
    localparam int unsigned NV = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, a_rready, a_gnt, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [MW-1:0] a_wmask;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_we, b_rready, b_gnt, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [MW-1:0] b_wmask;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          csb0, web0, init_done;
    logic [AW-1:0] addr0;
    logic [MW-1:0] wmask0;
    logic [DW-1:0] din0, dout0;

    data_array_ctrl dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wmask(a_wmask), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rready(a_rready), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wmask(b_wmask), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rready(b_rready), .b_rdata(b_rdata),
        .csb0(csb0), .web0(web0), .addr0(addr0), .wmask0(wmask0), .din0(din0),
        .dout0(dout0), .init_done(init_done)
    );

    always #5 clk = ~clk;

    // SRAM macro model: controls captured on posedge, array/dout0 act on the following negedge
    logic [DW-1:0] sram [NL];
    logic          l_csb, l_web;
    logic [AW-1:0] l_addr;
    logic [MW-1:0] l_mask;
    logic [DW-1:0] l_din;

    always @(posedge clk) begin
        l_csb  <= csb0;
        l_web  <= web0;
        l_addr <= addr0;
        l_mask <= wmask0;
        l_din  <= din0;
    end

    always @(negedge clk) begin
        logic [DW-1:0] w;
        if (l_csb === 1'b0) begin
            if (l_web === 1'b0) begin
                w = sram[l_addr];
                for (int i = 0; i < int'(MW); i++) if (l_mask[i]) w[i*8 +: 8] = l_din[i*8 +: 8];
                sram[l_addr] <= w;
            end else begin
                dout0 <= sram[l_addr];
            end
        end
    end

    typedef struct {
        logic          b;
        logic [DW-1:0] data;
    } sb_t;

    typedef struct {
        logic          b;
        logic          we;
        logic [AW-1:0] addr;
        logic [MW-1:0] mask;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;

    sb_t           sbq[$];
    logic [DW-1:0] exp_mem [NL];
    logic          last_b;
    int            checks = 0;
    int            errors = 0;
    vec_t          vecs [NV];

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic pop_chk(input logic side, input logic [DW-1:0] rd);
        sb_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_rvalid side=%b t=%0t", side, $time);
        end else begin
            e = sbq.pop_front();
            chk1("sb_owner", side, e.b);
            chkw("sb_rdata", rd, e.data);
        end
    endtask

    task automatic grant_seen(input logic side, input logic we, input logic [AW-1:0] addr,
                              input logic [MW-1:0] mask, input logic [DW-1:0] data);
        sb_t e;
        chk1("gnt_csb0", csb0, 1'b0);
        chk1("gnt_web0", web0, !we);
        chkw("gnt_addr0", DW'(addr0), DW'(addr));
        if (a_req && b_req) chk1("rr_order", side, !last_b);
        last_b = side;
        if (we) begin
            chkw("gnt_wmask0", DW'(wmask0), DW'(mask));
            for (int i = 0; i < int'(MW); i++) if (mask[i]) exp_mem[addr][i*8 +: 8] = data[i*8 +: 8];
        end else begin
            e.b    = side;
            e.data = exp_mem[addr];
            sbq.push_back(e);
        end
    endtask

    // Per-cycle observer: responses retire before the same cycle's grant is recorded
    task automatic monitor();
        if (rst) begin
            sbq.delete();
            last_b = 1'b1;
            return;
        end
        chk1("gnt_excl", a_gnt && b_gnt, 1'b0);
        chk1("rvalid_excl", a_rvalid && b_rvalid, 1'b0);
        if (a_rvalid && a_rready) pop_chk(1'b0, a_rdata);
        if (b_rvalid && b_rready) pop_chk(1'b1, b_rdata);
        if (a_gnt) grant_seen(1'b0, a_we, a_addr, a_wmask, a_wdata);
        if (b_gnt) grant_seen(1'b1, b_we, b_addr, b_wmask, b_wdata);
    endtask

    task automatic sample_pt();
        @(negedge clk);
        #2;
        monitor();
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic b, input logic we, input logic [AW-1:0] addr,
                          input logic [MW-1:0] mask, input logic [DW-1:0] data);
        logic got = 1'b0;
        if (b) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wmask = mask; b_wdata = data;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wmask = mask; a_wdata = data;
        end
        for (int t = 0; t < 20 && !got; t++) begin
            sample_pt();
            got = b ? b_gnt : a_gnt;
            next_cyc();
        end
        if (b) b_req = 1'b0;
        else   a_req = 1'b0;
        chk1("gnt_timeout", got, 1'b1);
    endtask

    task automatic sweep_chk();
        for (int i = 0; i < int'(NL); i++) exp_mem[i] = '0;
        for (int k = 0; k < int'(NL); k++) begin
            sample_pt();
            chk1("init_csb0", csb0, 1'b0);
            chk1("init_web0", web0, 1'b0);
            chkw("init_addr0", DW'(addr0), DW'(k));
            chkw("init_wmask0", DW'(wmask0), DW'({MW{1'b1}}));
            chkw("init_din0", din0, '0);
            chk1("init_done_low", init_done, 1'b0);
            next_cyc();
        end
        sample_pt();
        chk1("init_done_high", init_done, 1'b1);
        chk1("idle_csb0", csb0, 1'b1);
        next_cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, AW'(3),  {MW{1'b1}},   {32{8'hA5}}, '0};
        vecs[1] = '{1'b0, 1'b0, AW'(3),  '0,           '0,          {32{8'hA5}}};
        vecs[2] = '{1'b1, 1'b1, AW'(5),  MW'(1),       {32{8'hFF}}, '0};
        vecs[3] = '{1'b1, 1'b0, AW'(5),  '0,           '0,          DW'(8'hFF)};
        vecs[4] = '{1'b0, 1'b1, AW'(31), MW'(32'hF000_0000), {32{8'h3C}}, '0};
        vecs[5] = '{1'b1, 1'b0, AW'(31), '0,           '0,          {32'h3C3C_3C3C, 224'h0}};
        vecs[6] = '{1'b0, 1'b1, AW'(0),  '0,           {DW{1'b1}},  '0};
        vecs[7] = '{1'b0, 1'b0, AW'(0),  '0,           '0,          '0};

        for (int i = 0; i < int'(NL); i++) sram[i] = {8{32'hDEAD_BEEF}};
        last_b = 1'b1;
        rst = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = AW'(7); a_wmask = '0; a_wdata = '0; a_rready = 1'b1;
        b_req = 1'b1; b_we = 1'b1; b_addr = AW'(9); b_wmask = '1; b_wdata = '1; b_rready = 1'b1;

        // Reset forces the SRAM idle and the handshakes low even with requests present
        for (int c = 0; c < 3; c++) begin
            sample_pt();
            chk1("rst_csb0", csb0, 1'b1);
            chk1("rst_web0", web0, 1'b1);
            chk1("rst_init_done", init_done, 1'b0);
            chk1("rst_a_gnt", a_gnt, 1'b0);
            chk1("rst_b_gnt", b_gnt, 1'b0);
            chk1("rst_a_rvalid", a_rvalid, 1'b0);
            next_cyc();
        end

        // Partial sweep with requests held, then reset at counter 12
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            sample_pt();
            chkw("sweep1_addr0", DW'(addr0), DW'(k));
            chk1("sweep1_a_gnt", a_gnt, 1'b0);
            chk1("sweep1_b_gnt", b_gnt, 1'b0);
            next_cyc();
        end
        rst = 1'b1;
        a_req = 1'b0; b_req = 1'b0;
        sample_pt();
        chk1("midinit_rst_csb0", csb0, 1'b1);
        chk1("midinit_rst_init_done", init_done, 1'b0);
        next_cyc();
        rst = 1'b0;
        sweep_chk();

        access(1'b0, 1'b0, AW'(7), '0, '0);
        sample_pt();
        chk1("post_init_rvalid", a_rvalid, 1'b1);
        chkw("post_init_rdata", a_rdata, '0);
        next_cyc();

        for (int i = 0; i < int'(NV); i++) begin
            access(vecs[i].b, vecs[i].we, vecs[i].addr, vecs[i].mask, vecs[i].wdata);
            if (!vecs[i].we) begin
                sample_pt();
                chk1($sformatf("vec%0d_rvalid", i), vecs[i].b ? b_rvalid : a_rvalid, 1'b1);
                chk1($sformatf("vec%0d_other_rvalid", i), vecs[i].b ? a_rvalid : b_rvalid, 1'b0);
                chkw($sformatf("vec%0d_rdata", i), vecs[i].b ? b_rdata : a_rdata, vecs[i].exp);
                next_cyc();
            end
        end

        // Both requesters streaming reads: one access per cycle, alternating owners
        a_req = 1'b1; a_we = 1'b0; a_addr = AW'(3);
        b_req = 1'b1; b_we = 1'b0; b_addr = AW'(5);
        for (int c = 0; c < 8; c++) begin
            sample_pt();
            chk1("stream_csb0", csb0, 1'b0);
            chk1("stream_one_gnt", a_gnt ^ b_gnt, 1'b1);
            next_cyc();
        end
        a_req = 1'b0; b_req = 1'b0;
        sample_pt();
        next_cyc();

        // Stalled response on a blocks b until a_rready
        a_rready = 1'b0;
        access(1'b0, 1'b0, AW'(3), '0, '0);
        b_req = 1'b1; b_we = 1'b0; b_addr = AW'(5);
        for (int c = 0; c < 4; c++) begin
            sample_pt();
            chk1("stall_a_rvalid", a_rvalid, 1'b1);
            chk1("stall_b_gnt", b_gnt, 1'b0);
            chk1("stall_csb0", csb0, 1'b1);
            chkw("stall_a_rdata", a_rdata, {32{8'hA5}});
            next_cyc();
        end
        a_rready = 1'b1;
        sample_pt();
        chk1("release_b_gnt", b_gnt, 1'b1);
        next_cyc();
        b_req = 1'b0;
        sample_pt();
        chk1("release_b_rvalid", b_rvalid, 1'b1);
        next_cyc();

        // Reset while a read response is pending
        a_rready = 1'b0;
        access(1'b0, 1'b0, AW'(7), '0, '0);
        sample_pt();
        chk1("pend_a_rvalid", a_rvalid, 1'b1);
        next_cyc();
        rst = 1'b1;
        sample_pt();
        chk1("pend_rst_a_rvalid", a_rvalid, 1'b0);
        chk1("pend_rst_csb0", csb0, 1'b1);
        next_cyc();
        rst = 1'b0;
        a_rready = 1'b1;
        sweep_chk();
        chk1("post_rst_a_rvalid", a_rvalid, 1'b0);

        access(1'b1, 1'b0, AW'(3), '0, '0);
        sample_pt();
        chk1("resweep_rvalid", b_rvalid, 1'b1);
        chkw("resweep_rdata", b_rdata, '0);
        next_cyc();
        sample_pt();
        chk1("sb_drained", sbq.size() == 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
